// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - multi-precision adder stepping WORDS x 16-bit words through one 16-bit adder
// Optional subtract support is compiled in with MWADD_SUB_EN.

module full_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        overflow
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
  assign overflow    = (a[15] == b[15]) && (sum[15] != a[15]);
endmodule

module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                cin,
  input  logic                sub,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] result,
  output logic                cout,
  output logic                overflow
);
  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic           accept;
  logic [W-1:0]   a_reg, b_reg, b_in;
  logic           carry_reg, seed;
  logic [2:0]     idx;
  logic [IW-1:0]  base;
  logic           last;
  logic [15:0]    add_sum;
  logic           add_cout, add_ovf;

`ifdef MWADD_SUB_EN
  // Subtraction is A + ~B + 1; inverting once at acceptance keeps the word path plain.
  assign b_in = sub ? ~op_b : op_b;
  assign seed = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = op_b;
  assign seed       = cin;
`endif

  assign base = IW'({idx, 4'b0000});
  assign last = (idx == 3'(WORDS - 1));

  full_adder_16bit u_add (
    .a        (a_reg[base +: 16]),
    .b        (b_reg[base +: 16]),
    .cin      (carry_reg),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= 3'd0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= op_a;
      b_reg     <= b_in;
      carry_reg <= seed;
      idx       <= 3'd0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == RUN) begin
      result[base +: 16] <= add_sum;
      carry_reg          <= add_cout;
      // Top-word overflow is the signed overflow of the whole W-bit operation.
      if (last) begin
        cout     <= add_cout;
        overflow <= add_ovf;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - directed self-checking bench for multiword_add_seq (WORDS=4)

module tb_multiword_add_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] op_a, op_b;
  logic        cin, sub;
  logic        busy, done;
  logic [63:0] result;
  logic        cout, overflow;

  int tests = 0;
  int fails = 0;
  int lat;

  multiword_add_seq #(.WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start, returns the edge count from acceptance (counted as 1) to done.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic s, output int n);
    op_a  = a;
    op_b  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic finish_op(input string tag);
    step();
    check({tag, "_done_width"}, {63'b0, done}, 64'd0);
    check({tag, "_busy_low"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    step();
    step();
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_cout", {63'b0, cout}, 64'd0);
    check("rst_ovf", {63'b0, overflow}, 64'd0);
    rst = 1'b0;
    step();

    // Carry ripples from word 0 into word 1; done arrives after WORDS+1 edges including acceptance.
    op_a = 64'h0000_0000_0000_FFFF; op_b = 64'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_after_accept", {63'b0, busy}, 64'd1);
    check("t1_no_early_done", {63'b0, done}, 64'd0);
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_result", result, 64'h0000_0000_0001_0000);
    check("t1_cout", {63'b0, cout}, 64'd0);
    check("t1_ovf", {63'b0, overflow}, 64'd0);
    finish_op("t1");

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
    check("t2a_latency", 64'(lat), 64'd5);
    check("t2a_result", result, 64'd0);
    check("t2a_cout", {63'b0, cout}, 64'd1);
    check("t2a_ovf", {63'b0, overflow}, 64'd0);
    finish_op("t2a");

    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, lat);
    check("t2b_result", result, 64'd1);
    check("t2b_cout", {63'b0, cout}, 64'd1);
    check("t2b_ovf", {63'b0, overflow}, 64'd1);
    finish_op("t2b");

    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
    check("t3_result", result, 64'h8000_0000_0000_0000);
    check("t3_cout", {63'b0, cout}, 64'd0);
    check("t3_ovf", {63'b0, overflow}, 64'd1);
    finish_op("t3");

    // Starts during RUN and DONE must be dropped; operands changed after acceptance must not leak in.
    op_a = 64'd3; op_b = 64'd4; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    op_a = 64'hDEAD_0000_0000_0000; op_b = 64'h1234; start = 1'b1;
    step();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check("t4_latency", 64'(lat), 64'd5);
    check("t4_result", result, 64'd7);
    start = 1'b1; op_a = 64'd100; op_b = 64'd200;
    step();
    start = 1'b0;
    check("t4_done_ignored_busy", {63'b0, busy}, 64'd0);
    check("t4_result_held", result, 64'd7);
    step();
    check("t4_still_idle", {63'b0, busy}, 64'd0);

    // Held start re-arms every WORDS+2 cycles.
    begin
      int cyc = 0;
      int first_done = -1;
      int period = -1;
      op_a = 64'd1; op_b = 64'd1; cin = 1'b0; start = 1'b1;
      while (period < 0 && cyc < 40) begin
        step();
        cyc++;
        if (done) begin
          if (first_done < 0) first_done = cyc;
          else period = cyc - first_done;
        end
      end
      start = 1'b0;
      check("t4_held_period", 64'(period), 64'd6);
      check("t4_held_result", result, 64'd2);
      step();
      step();
    end

    // Reset during the second RUN cycle discards the operation.
    op_a = 64'h1111_1111_1111_1111; op_b = 64'h2222_2222_2222_2222; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t5_partial_word0", result, 64'h0000_0000_0000_3333);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", {63'b0, busy}, 64'd0);
    check("t5_rst_done", {63'b0, done}, 64'd0);
    check("t5_rst_result", result, 64'd0);
    check("t5_rst_cout", {63'b0, cout}, 64'd0);
    check("t5_rst_ovf", {63'b0, overflow}, 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (i == 2) rst = 1'b0;
        step();
        if (done) seen++;
      end
      check("t5_no_done_pulse", 64'(seen), 64'd0);
    end
    run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
    check("t5_after_latency", 64'(lat), 64'd5);
    check("t5_after_result", result, 64'd7);
    finish_op("t5");

    run_op(64'd5, 64'd10, 1'b0, 1'b1, lat);
`ifdef MWADD_SUB_EN
    check("t6_result", result, 64'hFFFF_FFFF_FFFF_FFFB);
    check("t6_cout", {63'b0, cout}, 64'd0);
`else
    check("t6_result", result, 64'd15);
    check("t6_cout", {63'b0, cout}, 64'd0);
`endif
    check("t6_ovf", {63'b0, overflow}, 64'd0);
    finish_op("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
